// File: rtl/polyphase_splitter_if.sv
// Pixel-stream interface for the polyphase splitter: raster-order input beats
// in, phase-tagged beats out.
//
// Handshake: a beat transfers on a rising clk edge where valid && ready are both
// high. A source holds valid and its payload stable until the transfer. ready may
// depend combinationally on the other side's state but never on valid.
interface polyphase_splitter_if #(
    parameter int WIDTH = 16,
    parameter int CH    = 1,
    parameter int ROWS  = 224,
    parameter int COLS  = 224
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic                  in_valid;
    logic                  in_ready;
    logic [CH*WIDTH-1:0]   in_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [CH*WIDTH-1:0]   out_data;
    logic [1:0]            out_phase;
    logic [RW-1:0]         out_row;
    logic [CW-1:0]         out_col;

    // master: the pixel source and output sink around the splitter
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_phase, out_row, out_col
    );

    // slave: the splitter itself
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_phase, out_row, out_col
    );
endinterface

// File: rtl/polyphase_splitter.sv
// Splits a raster pixel stream into four 2x2 polyphase sub-images (tagged beats)
// and decomposes a KSIZE x KSIZE kernel into the matching four sub-kernels.
module polyphase_splitter #(
    parameter int WIDTH = 16,
    parameter int ROWS  = 224,
    parameter int COLS  = 224,
    parameter int CH    = 1,
    parameter int KSIZE = 3,
    localparam int KH   = (KSIZE + 1) / 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [KSIZE*KSIZE*WIDTH-1:0] kernel_in,
    polyphase_splitter_if.slave         stream,
    output logic [KH*KH*WIDTH-1:0]      k_ee,
    output logic [KH*KH*WIDTH-1:0]      k_eo,
    output logic [KH*KH*WIDTH-1:0]      k_oe,
    output logic [KH*KH*WIDTH-1:0]      k_oo,
    output logic                        kernel_valid,
    output logic                        busy,
    output logic                        done,
    output logic [2:0]                  state_dbg
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int KW = KH * KH * WIDTH;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_K = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                in_ready_c;
    logic                in_acc;
    logic                start_acc;
    logic                last_pix;
    logic [RW-1:0]       row_cnt;
    logic [CW-1:0]       col_cnt;
    logic                out_valid_q;
    logic [CH*WIDTH-1:0] out_data_q;
    logic [1:0]          out_phase_q;
    logic [RW-1:0]       out_row_q;
    logic [CW-1:0]       out_col_q;
    logic [4*KW-1:0]     sub_k;
    logic [4*KW-1:0]     k_q;
    logic                kv_q;

    assign start_acc = (state == S_IDLE) && start;
    assign in_acc    = stream.in_valid && in_ready_c;
    assign last_pix  = (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // DRAIN leaves as soon as the output register is empty or empties this edge.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LOAD_K;
            S_LOAD_K: state_nxt = S_STREAM;
            S_STREAM: if (in_acc && last_pix) state_nxt = S_DRAIN;
            S_DRAIN:  if (!out_valid_q || stream.out_ready) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        in_ready_c = 1'b0;
        case (state)
            S_LOAD_K: busy = 1'b1;
            S_STREAM: begin
                busy       = 1'b1;
                in_ready_c = !out_valid_q || stream.out_ready;
            end
            S_DRAIN:  busy = 1'b1;
            S_DONE:   done = 1'b1;
            default:  ;
        endcase
    end

    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (start_acc) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (in_acc) begin
            if (col_cnt == COL_LAST) begin
                col_cnt <= '0;
                row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Single-entry output register; refilled on the same edge it drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_phase_q <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else if (in_acc) begin
            out_valid_q <= 1'b1;
            out_data_q  <= stream.in_data;
            out_phase_q <= {row_cnt[0], col_cnt[0]};
            out_row_q   <= row_cnt >> 1;
            out_col_q   <= col_cnt >> 1;
        end else if (stream.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign stream.in_ready  = in_ready_c;
    assign stream.out_valid = out_valid_q;
    assign stream.out_data  = out_data_q;
    assign stream.out_phase = out_phase_q;
    assign stream.out_row   = out_row_q;
    assign stream.out_col   = out_col_q;

    // Sub-kernel pq tap (i,j) comes from kernel tap (2i+p, 2j+q); taps past the edge are zero.
    for (genvar p = 0; p < 2; p++) begin : g_p
        for (genvar q = 0; q < 2; q++) begin : g_q
            for (genvar i = 0; i < KH; i++) begin : g_i
                for (genvar j = 0; j < KH; j++) begin : g_j
                    localparam int KR  = 2 * i + p;
                    localparam int KC  = 2 * j + q;
                    localparam int DST = (p * 2 + q) * KW + (i * KH + j) * WIDTH;
                    if (KR < KSIZE && KC < KSIZE) begin : g_tap
                        assign sub_k[DST +: WIDTH] = kernel_in[(KR * KSIZE + KC) * WIDTH +: WIDTH];
                    end else begin : g_pad
                        assign sub_k[DST +: WIDTH] = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q  <= '0;
            kv_q <= 1'b0;
        end else if (start_acc) begin
            kv_q <= 1'b0;
        end else if (state == S_LOAD_K) begin
            k_q  <= sub_k;
            kv_q <= 1'b1;
        end
    end

    assign k_ee         = k_q[0*KW +: KW];
    assign k_eo         = k_q[1*KW +: KW];
    assign k_oe         = k_q[2*KW +: KW];
    assign k_oo         = k_q[3*KW +: KW];
    assign kernel_valid = kv_q;
endmodule

// File: doc/polyphase_splitter.md
POLYPHASE_SPLITTER -- requirements
Module: polyphase_splitter

Interface
REQ-001 Parameter WIDTH, 16, signed bits per sample.
REQ-002 Parameter ROWS, 224, frame rows (>=2, odd allowed).
REQ-003 Parameter COLS, 224, frame columns (>=2, odd allowed).
REQ-004 Parameter CH, 1, channels per pixel beat.
REQ-005 Parameter KSIZE, 3, kernel side (odd, >=3); KH=(KSIZE+1)/2.
REQ-006 Port clk  in  1  single clock, all logic on rising edge.
REQ-007 Port rst  in  1  asynchronous, active-high reset.
REQ-008 Port start  in  1  one-cycle pulse, begins a frame.
REQ-009 Port kernel_in  in  KSIZE*KSIZE*WIDTH  row-major; element (r,c) at bits [(r*KSIZE+c)*WIDTH +: WIDTH].
REQ-010 Port in_valid / in_ready  in / out  1 / 1  pixel-stream handshake, raster order.
REQ-011 Port in_data  in  CH*WIDTH  channel k at bits [k*WIDTH +: WIDTH].
REQ-012 Port out_valid / out_ready  out / in  1 / 1  phase-tagged output handshake.
REQ-013 Port out_data  out  CH*WIDTH  pixel, same packing as in_data.
REQ-014 Port out_phase  out  2  {row parity, col parity}: 0=ee, 1=eo, 2=oe, 3=oo.
REQ-015 Port out_row / out_col  out  clog2(ROWS)/clog2(COLS)  sub-image coordinates (r/2, c/2).
REQ-016 Port k_ee, k_eo, k_oe, k_oo  out  KH*KH*WIDTH each  sub-kernels, same packing with KH.
REQ-017 Port kernel_valid  out  1  sub-kernels hold current frame's values.
REQ-018 Port busy  out  1  high in LOAD_K, STREAM, DRAIN.
REQ-019 Port done  out  1  one-cycle pulse at frame completion.

Function
REQ-020 FSM states IDLE, LOAD_K, STREAM, DRAIN, DONE; IDLE->LOAD_K on start; LOAD_K->STREAM after 1 cycle; STREAM->DRAIN when pixel (ROWS-1,COLS-1) accepted; DRAIN->DONE when output register empty; DONE->IDLE after 1 cycle.
REQ-021 start outside IDLE shall be ignored (no restart, no counter change).
REQ-022 In LOAD_K, sub-kernel pq element (i,j) = kernel_in(2i+p, 2j+q) if both indices < KSIZE, else 0; kernel_valid rises the next cycle.
REQ-023 kernel_valid shall fall when start is accepted and rise again after LOAD_K; sub-kernels hold otherwise.
REQ-024 in_ready = (state==STREAM) && (!out_valid || out_ready).
REQ-025 Accepted pixel at (r,c) appears on out_* next cycle: out_phase={r[0],c[0]}, out_row=r>>1, out_col=c>>1, data unmodified (latency 1).
REQ-026 out_* shall hold stable while out_valid && !out_ready.
REQ-027 Column counter wraps COLS-1->0 incrementing row; both counters clear on start acceptance.
REQ-028 Odd ROWS/COLS: even phases carry ceil(N/2) rows/cols, odd phases floor(N/2); no padding beats emitted.
REQ-029 Exactly ROWS*COLS output beats per frame; done pulses in DONE state, one cycle after the last beat is accepted.
REQ-030 Simultaneous accept-in and accept-out in one cycle shall sustain 1 pixel/cycle throughput.

Reset
REQ-031 rst asserted (any state, mid-frame included): state=IDLE, counters=0, out_valid=0, in_ready=0, out_data/out_phase/out_row/out_col=0, all sub-kernels=0, kernel_valid=0, busy=0, done=0; partially streamed frame discarded.

Verification
REQ-032 ROWS=COLS=4, CH=1, data=r*4+c, out_ready=1 -> 16 beats; pixel 5 gives phase 3, row 0, col 0; pixel 14 gives phase 2, row 1, col 1; done 1 cycle after beat 16.
REQ-033 KSIZE=3, kernel 1..9 row-major -> k_ee=[1,3;7,9], k_eo=[2,0;8,0], k_oe=[4,6;0,0], k_oo=[5,0;0,0], kernel_valid=1 at cycle after LOAD_K.
REQ-034 ROWS=5, COLS=3 -> phase counts ee=6, eo=3, oe=4, oo=2; max out_row for phase 0 = 2.
REQ-035 out_ready toggled 1-0-1 randomly -> in_ready low whenever out_valid && !out_ready; no beat lost or duplicated; outputs stable during stall.
REQ-036 start pulsed during STREAM -> ignored, beat count still ROWS*COLS; rst asserted after 7 beats -> all outputs zero same cycle, next start yields full clean frame.
